// File: rtl/point_config_ctrl.sv
// Button/switch front end for the bouncing-point demo: sync, debounce,
// press-event extraction and the EDIT/RUN configuration state machine.
module point_config_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] btn_n,
  input  logic       sw_rcm,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [2:0] z,
  output logic [2:0] c,
  output logic       rcm,
  output logic       pause,
  output logic       point_rstn,
  output logic       mode,
  output logic [1:0] field
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_EDIT, S_RUN} state_t;

  logic [3:0]    r_btn_s1, r_btn_s2;
  logic          r_rcm_s1, r_rcm_s2;
  logic [3:0]    r_deb, r_deb_d, r_evt;
  logic [CW-1:0] r_cnt [4];

  state_t        r_state;
  logic [2:0]    r_x, r_y, r_z, r_c;
  logic [1:0]    r_field;
  logic          r_mode, r_pause, r_point_rstn;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_btn_s1 <= '1;
      r_btn_s2 <= '1;
      r_rcm_s1 <= 1'b0;
      r_rcm_s2 <= 1'b0;
    end else begin
      r_btn_s1 <= btn_n;
      r_btn_s2 <= r_btn_s1;
      r_rcm_s1 <= sw_rcm;
      r_rcm_s2 <= r_rcm_s1;
    end
  end

  // Event is taken from the delayed debounced level so the FSM acts one
  // cycle after the debounced edge, giving the sync+debounce+1 latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_deb   <= '1;
      r_deb_d <= '1;
      r_evt   <= '0;
      for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      r_evt   <= r_deb_d & ~r_deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_btn_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_deb[i] <= r_btn_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Priority launch > pause > next > inc; lower events in the same cycle are dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_EDIT;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_c          <= 3'b001;
      r_field      <= '0;
      r_mode       <= 1'b0;
      r_pause      <= 1'b0;
      r_point_rstn <= 1'b0;
    end else begin
      unique case (r_state)
        S_EDIT: begin
          if (r_evt[2]) begin
            r_state      <= S_RUN;
            r_mode       <= 1'b1;
            r_point_rstn <= 1'b1;
          end else if (!r_evt[3]) begin
            if (r_evt[1]) begin
              r_field <= r_field + 2'd1;
            end else if (r_evt[0]) begin
              unique case (r_field)
                2'd0: r_x <= r_x + 3'd1;
                2'd1: r_y <= r_y + 3'd1;
                2'd2: r_z <= r_z + 3'd1;
                2'd3: r_c <= (r_c == 3'd7) ? 3'd1 : r_c + 3'd1;
              endcase
            end
          end
        end
        S_RUN: begin
          if (r_evt[2]) begin
            r_state      <= S_EDIT;
            r_mode       <= 1'b0;
            r_point_rstn <= 1'b0;
            r_pause      <= 1'b0;
          end else if (r_evt[3]) begin
            r_pause <= ~r_pause;
          end
        end
        default: r_state <= S_EDIT;
      endcase
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign z          = r_z;
  assign c          = r_c;
  assign field      = r_field;
  assign mode       = r_mode;
  assign pause      = r_pause;
  assign point_rstn = r_point_rstn;
  assign rcm        = r_rcm_s2;

endmodule

// File: tb/tb_point_config_ctrl.sv
// Randomized self-checking bench for point_config_ctrl against a
// press-level behavioural model (DEBOUNCE_CYCLES = 4).
module tb_point_config_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] btn_n;
  logic       sw_rcm;
  logic [2:0] x, y, z, c;
  logic       rcm, pause, point_rstn, mode;
  logic [1:0] field;

  point_config_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .btn_n(btn_n), .sw_rcm(sw_rcm),
    .x(x), .y(y), .z(z), .c(c), .rcm(rcm), .pause(pause),
    .point_rstn(point_rstn), .mode(mode), .field(field)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state, updated once per accepted press.
  int m_x, m_y, m_z, m_c, m_field, m_mode, m_pause, m_rcm;

  logic [17:0] act;
  assign act = {x, y, z, c, field, mode, pause, point_rstn, rcm};

  function automatic logic [17:0] exp_vec();
    return {3'(m_x), 3'(m_y), 3'(m_z), 3'(m_c), 2'(m_field),
            1'(m_mode), 1'(m_pause), 1'(m_mode), 1'(m_rcm)};
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_z = 0; m_c = 1; m_field = 0;
    m_mode = 0; m_pause = 0; m_rcm = 0;
  endtask

  task automatic model_apply(input logic [3:0] mask);
    if (mask[2]) begin
      if (m_mode == 1) begin m_mode = 0; m_pause = 0; end
      else m_mode = 1;
    end else if (mask[3]) begin
      if (m_mode == 1) m_pause = 1 - m_pause;
    end else if (mask[1]) begin
      if (m_mode == 0) m_field = (m_field + 1) % 4;
    end else if (mask[0]) begin
      if (m_mode == 0) begin
        case (m_field)
          0: m_x = (m_x + 1) % 8;
          1: m_y = (m_y + 1) % 8;
          2: m_z = (m_z + 1) % 8;
          default: m_c = (m_c == 7) ? 1 : m_c + 1;
        endcase
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    btn_n = ~mask;
    step(12);
    btn_n = '1;
    step(12);
    model_apply(mask);
  endtask

  task automatic test_reset();
    resetn = 1'b0; btn_n = '1; sw_rcm = 1'b0;
    model_reset();
    step(3);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL reset_hold: got %h expected %h", act, exp_vec());
    else n_pass++;
    resetn = 1'b1;
    step(20);
    n_checks++;
    if (act !== 18'({3'd0, 3'd0, 3'd0, 3'b001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}))
      $display("FAIL reset_idle: got %h expected %h", act,
               18'({3'd0, 3'd0, 3'd0, 3'b001, 2'd0, 4'b0000}));
    else n_pass++;
  endtask

  task automatic test_edit();
    for (int i = 0; i < 9; i++) begin
      press(4'b0001);
      n_checks++;
      if (act !== exp_vec()) $display("FAIL edit_inc_x[%0d]: got %h expected %h", i, act, exp_vec());
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) press(4'b0010);
    for (int i = 0; i < 7; i++) begin
      press(4'b0001);
      n_checks++;
      if (act !== exp_vec()) $display("FAIL edit_inc_c[%0d]: got %h expected %h", i, act, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if ({x, field, c} !== {3'd1, 2'd3, 3'd1})
      $display("FAIL edit_wrap: got x=%0d field=%0d c=%0d expected x=1 field=3 c=1", x, field, c);
    else n_pass++;
  endtask

  task automatic test_glitch();
    btn_n = 4'b1110;
    step(3);
    btn_n = '1;
    step(12);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL glitch_ignored: got %h expected %h", act, exp_vec());
    else n_pass++;
    btn_n = 4'b1110;
    step(7);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL latency_early: got %h expected %h", act, exp_vec());
    else n_pass++;
    step(1);
    model_apply(4'b0001);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL latency_edge: got %h expected %h", act, exp_vec());
    else n_pass++;
    step(12);
    btn_n = '1;
    step(12);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL held_single_event: got %h expected %h", act, exp_vec());
    else n_pass++;
  endtask

  task automatic test_run();
    while (m_field != 0) press(4'b0010);
    while (m_x != 5) press(4'b0001);
    btn_n = 4'b1011;
    step(7);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL launch_early: got %h expected %h", act, exp_vec());
    else n_pass++;
    step(1);
    model_apply(4'b0100);
    n_checks++;
    if ({mode, point_rstn} !== 2'b11 || act !== exp_vec())
      $display("FAIL launch_edge: got %h expected %h", act, exp_vec());
    else n_pass++;
    step(12);
    btn_n = '1;
    step(12);
    press(4'b0001);
    press(4'b0010);
    n_checks++;
    if (x !== 3'd5 || act !== exp_vec())
      $display("FAIL run_hold: got %h expected %h", act, exp_vec());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      press(4'b1000);
      n_checks++;
      if (act !== exp_vec()) $display("FAIL run_pause[%0d]: got %h expected %h", i, act, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_launch_pause_same();
    press(4'b1000);
    n_checks++;
    if (pause !== 1'b1) $display("FAIL pause_set: got %b expected 1", pause);
    else n_pass++;
    press(4'b1100);
    n_checks++;
    if ({mode, pause, point_rstn} !== 3'b000 || act !== exp_vec())
      $display("FAIL launch_over_pause: got %h expected %h", act, exp_vec());
    else n_pass++;
  endtask

  task automatic test_rcm();
    sw_rcm = 1'b1;
    step(1);
    n_checks++;
    if (rcm !== 1'b0) $display("FAIL rcm_lat1: got %b expected 0", rcm);
    else n_pass++;
    step(1);
    n_checks++;
    if (rcm !== 1'b1) $display("FAIL rcm_lat2: got %b expected 1", rcm);
    else n_pass++;
    sw_rcm = 1'b0;
    m_rcm = 0;
    step(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [3:0] mask;
      sw_rcm = 1'($urandom_range(0, 1));
      m_rcm = int'(sw_rcm);
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        btn_n = '1;
        btn_n[b] = 1'b0;
        step($urandom_range(1, 3));
        btn_n = '1;
        step(10);
        n_checks++;
        if (act !== exp_vec()) $display("FAIL rand_glitch[%0d]: got %h expected %h", i, act, exp_vec());
        else n_pass++;
      end
      mask = 4'($urandom_range(1, 15));
      press(mask);
      n_checks++;
      if (act !== exp_vec())
        $display("FAIL rand_press[%0d] mask=%b: got %h expected %h", i, mask, act, exp_vec());
      else n_pass++;
    end
    sw_rcm = 1'b0;
    m_rcm = 0;
    step(3);
  endtask

  task automatic test_reset_mid_press();
    if (m_mode == 0) press(4'b0100);
    btn_n = 4'b1011;
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    model_reset();
    n_checks++;
    if (act !== exp_vec()) $display("FAIL midpress_reset: got %h expected %h", act, exp_vec());
    else n_pass++;
    step(7);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL midpress_early: got %h expected %h", act, exp_vec());
    else n_pass++;
    step(1);
    model_apply(4'b0100);
    n_checks++;
    if (mode !== 1'b1 || act !== exp_vec())
      $display("FAIL midpress_event: got %h expected %h", act, exp_vec());
    else n_pass++;
    step(12);
    btn_n = '1;
    step(12);
    n_checks++;
    if (act !== exp_vec()) $display("FAIL midpress_single: got %h expected %h", act, exp_vec());
    else n_pass++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    btn_n  = '1;
    sw_rcm = 1'b0;
    model_reset();
    step(1);
    test_reset();
    test_edit();
    test_glitch();
    test_run();
    test_launch_pause_same();
    test_rcm();
    test_random();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
